instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/instruction_fetch_if.sv | 24 ++
 rtl/instruction_fetch_pc_unit.sv | 37 +++
 rtl/instruction_fetch.sv | 108 ++++++++++
 tb/tb_instruction_fetch.sv | 358 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: fetch FSM encoding, IF/ID payload,
// bubble word and the fetch address legality rule.
package cpu_pkg;

   typedef enum logic {
      S_RUN   = 1'b0,
      S_FAULT = 1'b1
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc_plus4;
      logic        valid;
   } if_id_t;

   localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
   localparam logic [31:0] WORD_BYTES = 32'd4;

   // A fetch address must be word aligned and leave a full word inside memory.
   function automatic logic addr_legal(input logic [31:0] addr, input logic [31:0] depth);
      return (addr[1:0] == 2'b00) && (addr <= depth - WORD_BYTES);
   endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch stage bus: pipeline control in, instruction memory port, IF/ID register out.
interface instruction_fetch_if;
   logic        stall;
   logic        flush;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_pc_plus4;
   logic        if_id_valid;
   logic        fault;

   modport master (
      input  stall, flush, redirect_valid, redirect_pc, imem_instr,
      output imem_addr, if_id_instr, if_id_pc, if_id_pc_plus4, if_id_valid, fault
   );

   modport slave (
      output stall, flush, redirect_valid, redirect_pc, imem_instr,
      input  imem_addr, if_id_instr, if_id_pc, if_id_pc_plus4, if_id_valid, fault
   );
endinterface

// File: rtl/instruction_fetch_pc_unit.sv
// Program counter register with sequential/redirect next-PC selection and
// legality flags for both the current PC and the redirect target.
module pc_unit
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned IMEM_DEPTH = 100
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        advance,
   input  logic [31:0] target,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        pc_legal,
   output logic        target_legal
);

   localparam logic [31:0] DEPTH = 32'(IMEM_DEPTH);

   // Wraps modulo 2^32; a wrapped value is caught by the range check.
   assign pc_plus4     = pc + WORD_BYTES;
   assign pc_legal     = addr_legal(pc, DEPTH);
   assign target_legal = addr_legal(target, DEPTH);

   always_ff @(posedge clk) begin
      if (!rst) begin
         pc <= RESET_PC;
      end else if (load) begin
         pc <= target;
      end else if (advance) begin
         pc <= pc_plus4;
      end
   end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: drives the PC to instruction memory and captures
// the returned word into the IF/ID register; parks in FAULT on a bad address.
//
//   state   | meaning
//   S_RUN   | fetching; illegal PC seen here moves to S_FAULT
//   S_FAULT | PC frozen, IF/ID bubbled, waits for a legal redirect
module instruction_fetch
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned IMEM_DEPTH = 100,
   parameter logic [31:0] NOP_WORD   = NOP_INSTR
) (
   input  logic               clk,
   input  logic               rst,
   instruction_fetch_if.master bus
);

   localparam if_id_t BUBBLE = '{instr: NOP_WORD, pc: 32'h0, pc_plus4: 32'h0, valid: 1'b0};

   fetch_state_t state;
   if_id_t       if_id;
   logic         fault_q;
   logic         pc_load;
   logic         pc_adv;
   logic         pc_legal;
   logic         target_legal;
   logic [31:0]  pc;
   logic [31:0]  pc_plus4;

   pc_unit #(
      .RESET_PC   (RESET_PC),
      .IMEM_DEPTH (IMEM_DEPTH)
   ) u_pc (
      .clk          (clk),
      .rst          (rst),
      .load         (pc_load),
      .advance      (pc_adv),
      .target       (bus.redirect_pc),
      .pc           (pc),
      .pc_plus4     (pc_plus4),
      .pc_legal     (pc_legal),
      .target_legal (target_legal)
   );

   assign bus.imem_addr      = pc;
   assign bus.if_id_instr    = if_id.instr;
   assign bus.if_id_pc       = if_id.pc;
   assign bus.if_id_pc_plus4 = if_id.pc_plus4;
   assign bus.if_id_valid    = if_id.valid;
   assign bus.fault          = fault_q;

   always_comb begin
      pc_load = 1'b0;
      pc_adv  = 1'b0;
      case (state)
         S_RUN: begin
            if (bus.redirect_valid) begin
               pc_load = 1'b1;
            end else if (pc_legal && !bus.stall) begin
               pc_adv = 1'b1;
            end
         end
         S_FAULT: pc_load = bus.redirect_valid && target_legal;
         default: pc_load = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= S_RUN;
         fault_q <= 1'b0;
         if_id   <= BUBBLE;
      end else begin
         case (state)
            S_RUN: begin
               if (bus.redirect_valid) begin
                  if_id <= BUBBLE;
               end else if (!pc_legal) begin
                  // The illegal PC was loaded last edge; its fetch never completes.
                  state   <= S_FAULT;
                  fault_q <= 1'b1;
                  if_id   <= BUBBLE;
               end else if (bus.stall) begin
                  if (bus.flush) if_id <= BUBBLE;
               end else if (bus.flush) begin
                  if_id <= BUBBLE;
               end else begin
                  if_id <= '{instr: bus.imem_instr, pc: pc, pc_plus4: pc_plus4, valid: 1'b1};
               end
            end
            S_FAULT: begin
               if_id <= BUBBLE;
               if (bus.redirect_valid && target_legal) begin
                  state   <= S_RUN;
                  fault_q <= 1'b0;
               end
            end
            default: begin
               state   <= S_RUN;
               fault_q <= 1'b0;
               if_id   <= BUBBLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus a
// randomized run against a cycle-level behavioural model of the fetch rules.
module tb_instruction_fetch;

   localparam int unsigned DEPTH = 100;
   localparam logic [31:0] NOP   = 32'h0000_0000;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   logic [31:0] mem [0:24];

   // behavioural model state
   logic [31:0] m_pc;
   logic        m_fault;
   logic [31:0] m_instr;
   logic [31:0] m_ipc;
   logic [31:0] m_ipc4;
   logic        m_valid;

   instruction_fetch_if ifc ();
   instruction_fetch_if ifc2 ();

   instruction_fetch #(
      .RESET_PC   (32'h0000_0000),
      .IMEM_DEPTH (DEPTH),
      .NOP_WORD   (NOP)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc.master)
   );

   instruction_fetch #(
      .RESET_PC   (32'h0000_0002),
      .IMEM_DEPTH (DEPTH),
      .NOP_WORD   (NOP)
   ) dut_bad_reset (
      .clk (clk),
      .rst (rst),
      .bus (ifc2.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (a[1:0] == 2'b00 && a <= 32'd96) return mem[a[6:2]];
      return 32'hBAD0_BAD0;
   endfunction

   function automatic logic legal(input logic [31:0] a);
      return (a % 4 == 0) && (a <= DEPTH - 4);
   endfunction

   assign ifc.imem_instr      = mem_rd(ifc.imem_addr);
   assign ifc2.imem_instr     = 32'h0;
   assign ifc2.stall          = 1'b0;
   assign ifc2.flush          = 1'b0;
   assign ifc2.redirect_valid = 1'b0;
   assign ifc2.redirect_pc    = 32'h0;

   task automatic clear_ifid();
      m_instr = NOP;
      m_ipc   = 32'h0;
      m_ipc4  = 32'h0;
      m_valid = 1'b0;
   endtask

   task automatic model_step();
      if (!rst) begin
         m_pc    = 32'h0;
         m_fault = 1'b0;
         clear_ifid();
      end else if (!m_fault) begin
         if (ifc.redirect_valid) begin
            m_pc = ifc.redirect_pc;
            clear_ifid();
         end else if (!legal(m_pc)) begin
            m_fault = 1'b1;
            clear_ifid();
         end else if (ifc.stall) begin
            if (ifc.flush) clear_ifid();
         end else begin
            if (ifc.flush) begin
               clear_ifid();
            end else begin
               m_instr = mem_rd(m_pc);
               m_ipc   = m_pc;
               m_ipc4  = m_pc + 4;
               m_valid = 1'b1;
            end
            m_pc = m_pc + 4;
         end
      end else begin
         clear_ifid();
         if (ifc.redirect_valid && legal(ifc.redirect_pc)) begin
            m_pc    = ifc.redirect_pc;
            m_fault = 1'b0;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic set_in(input logic st, input logic fl, input logic rv, input logic [31:0] rp);
      ifc.stall          = st;
      ifc.flush          = fl;
      ifc.redirect_valid = rv;
      ifc.redirect_pc    = rp;
   endtask

   task automatic do_reset();
      set_in(1'b0, 1'b0, 1'b0, 32'h0);
      rst = 1'b0;
      tick();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      logic [129:0] obs;
      logic [129:0] exp;
      set_in(1'b1, 1'b1, 1'b1, 32'h0000_0042);
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         obs = {ifc.imem_addr, ifc.fault, ifc.if_id_valid, ifc.if_id_instr, ifc.if_id_pc, ifc.if_id_pc_plus4};
         exp = {32'h0, 1'b0, 1'b0, NOP, 32'h0, 32'h0};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL reset_state cycle %0d got %h want %h", i, obs, exp);
         end
      end
      rst = 1'b1;
      set_in(1'b0, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic test_sequential();
      logic [31:0] seq [3];
      logic [96:0] obs;
      logic [96:0] exp;
      seq = '{32'h00221820, 32'h8C4B0001, 32'hAC430001};
      do_reset();
      for (int k = 0; k < 3; k++) begin
         tick();
         obs = {ifc.if_id_instr, ifc.if_id_pc, ifc.if_id_pc_plus4, ifc.if_id_valid};
         exp = {seq[k], 32'(4 * k), 32'(4 * k + 4), 1'b1};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL sequential fetch %0d got %h want %h", k, obs, exp);
         end
      end
   endtask

   task automatic test_stall();
      logic [96:0] obs;
      do_reset();
      tick();
      ifc.stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         obs = {ifc.imem_addr, ifc.if_id_instr, ifc.if_id_pc, ifc.if_id_valid};
         checks++;
         if (obs !== {32'd4, 32'h00221820, 32'd0, 1'b1}) begin
            errors++;
            $display("FAIL stall_hold cycle %0d got %h want %h", i, obs, {32'd4, 32'h00221820, 32'd0, 1'b1});
         end
      end
      ifc.stall = 1'b0;
      tick();
      checks++;
      if ({ifc.if_id_instr, ifc.if_id_pc} !== {32'h8C4B0001, 32'd4}) begin
         errors++;
         $display("FAIL stall_release got %h/%h want 8c4b0001/4", ifc.if_id_instr, ifc.if_id_pc);
      end
   endtask

   task automatic test_redirect_over_stall();
      do_reset();
      tick();
      tick();
      checks++;
      if (ifc.imem_addr !== 32'd8) begin
         errors++;
         $display("FAIL redirect_setup pc got %h want 8", ifc.imem_addr);
      end
      set_in(1'b1, 1'b0, 1'b1, 32'h0);
      tick();
      checks++;
      if ({ifc.imem_addr, ifc.if_id_valid, ifc.if_id_instr} !== {32'd0, 1'b0, NOP}) begin
         errors++;
         $display("FAIL redirect_stall got pc %h valid %b instr %h want 0/0/nop", ifc.imem_addr, ifc.if_id_valid, ifc.if_id_instr);
      end
      set_in(1'b0, 1'b0, 1'b0, 32'h0);
      tick();
      checks++;
      if ({ifc.if_id_instr, ifc.if_id_pc, ifc.if_id_valid} !== {32'h00221820, 32'd0, 1'b1}) begin
         errors++;
         $display("FAIL redirect_refetch got %h/%h/%b want 00221820/0/1", ifc.if_id_instr, ifc.if_id_pc, ifc.if_id_valid);
      end
   endtask

   task automatic test_fault_recovery();
      logic [65:0] obs;
      do_reset();
      tick();
      set_in(1'b0, 1'b0, 1'b1, 32'h6);
      tick();
      set_in(1'b0, 1'b0, 1'b0, 32'h0);
      tick();
      checks++;
      obs = {ifc.imem_addr, ifc.fault, ifc.if_id_valid, 32'h0};
      if (obs !== {32'd6, 1'b1, 1'b0, 32'h0}) begin
         errors++;
         $display("FAIL misaligned_fault got pc %h fault %b valid %b want 6/1/0", ifc.imem_addr, ifc.fault, ifc.if_id_valid);
      end
      for (int i = 0; i < 5; i++) begin
         ifc.stall = 1'($urandom_range(0, 1));
         ifc.flush = 1'($urandom_range(0, 1));
         tick();
         checks++;
         if ({ifc.imem_addr, ifc.fault, ifc.if_id_valid} !== {32'd6, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL fault_frozen cycle %0d got pc %h fault %b valid %b", i, ifc.imem_addr, ifc.fault, ifc.if_id_valid);
         end
      end
      set_in(1'b0, 1'b0, 1'b1, 32'd100);
      tick();
      checks++;
      if ({ifc.imem_addr, ifc.fault} !== {32'd6, 1'b1}) begin
         errors++;
         $display("FAIL illegal_redirect_in_fault got pc %h fault %b want 6/1", ifc.imem_addr, ifc.fault);
      end
      set_in(1'b0, 1'b0, 1'b1, 32'd4);
      tick();
      checks++;
      if ({ifc.imem_addr, ifc.fault, ifc.if_id_valid} !== {32'd4, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL fault_exit got pc %h fault %b valid %b want 4/0/0", ifc.imem_addr, ifc.fault, ifc.if_id_valid);
      end
      set_in(1'b0, 1'b0, 1'b0, 32'h0);
      tick();
      checks++;
      if ({ifc.if_id_instr, ifc.if_id_pc, ifc.if_id_valid, ifc.fault} !== {32'h8C4B0001, 32'd4, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL fault_exit_fetch got %h/%h/%b want 8c4b0001/4/1", ifc.if_id_instr, ifc.if_id_pc, ifc.if_id_valid);
      end
   endtask

   task automatic test_range_end();
      do_reset();
      repeat (25) tick();
      checks++;
      if ({ifc.if_id_instr, ifc.if_id_pc, ifc.if_id_valid, ifc.imem_addr, ifc.fault} !== {mem[24], 32'd96, 1'b1, 32'd100, 1'b0}) begin
         errors++;
         $display("FAIL last_word_fetch got %h/%h/%b pc %h fault %b want %h/60/1/64/0",
                  ifc.if_id_instr, ifc.if_id_pc, ifc.if_id_valid, ifc.imem_addr, ifc.fault, mem[24]);
      end
      tick();
      checks++;
      if ({ifc.fault, ifc.if_id_valid, ifc.imem_addr} !== {1'b1, 1'b0, 32'd100}) begin
         errors++;
         $display("FAIL range_fault got fault %b valid %b pc %h want 1/0/64", ifc.fault, ifc.if_id_valid, ifc.imem_addr);
      end
   endtask

   task automatic test_reset_in_fault();
      set_in(1'b1, 1'b0, 1'b0, 32'h0);
      rst = 1'b0;
      tick();
      checks++;
      if ({ifc.imem_addr, ifc.fault, ifc.if_id_valid} !== {32'd0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_in_fault got pc %h fault %b valid %b want 0/0/0", ifc.imem_addr, ifc.fault, ifc.if_id_valid);
      end
      rst = 1'b1;
      ifc.stall = 1'b0;
   endtask

   task automatic test_illegal_reset_pc();
      set_in(1'b0, 1'b0, 1'b0, 32'h0);
      rst = 1'b0;
      tick();
      checks++;
      if ({ifc2.imem_addr, ifc2.fault} !== {32'd2, 1'b0}) begin
         errors++;
         $display("FAIL bad_reset_pc_in_reset got pc %h fault %b want 2/0", ifc2.imem_addr, ifc2.fault);
      end
      rst = 1'b1;
      tick();
      checks++;
      if ({ifc2.fault, ifc2.if_id_valid, ifc2.imem_addr} !== {1'b1, 1'b0, 32'd2}) begin
         errors++;
         $display("FAIL bad_reset_pc_fault got fault %b valid %b pc %h want 1/0/2", ifc2.fault, ifc2.if_id_valid, ifc2.imem_addr);
      end
   endtask

   task automatic test_random();
      logic [129:0] obs;
      logic [129:0] exp;
      logic [31:0]  tgt;
      int           sel;
      do_reset();
      for (int i = 0; i < 600; i++) begin
         sel = int'($urandom_range(0, 9));
         case (sel)
            6:       tgt = 32'($urandom_range(0, 99)) | 32'h1;
            7:       tgt = 32'd100;
            8:       tgt = 32'hFFFF_FFFC;
            9:       tgt = $urandom;
            default: tgt = {25'h0, 5'($urandom_range(0, 24)), 2'b00};
         endcase
         set_in($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0, tgt);
         rst = ($urandom_range(0, 63) != 0);
         tick();
         obs = {ifc.imem_addr, ifc.fault, ifc.if_id_valid, ifc.if_id_instr, ifc.if_id_pc, ifc.if_id_pc_plus4};
         exp = {m_pc, m_fault, m_valid, m_instr, m_ipc, m_ipc4};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL random cycle %0d got %h want %h", i, obs, exp);
         end
      end
      rst = 1'b1;
      set_in(1'b0, 1'b0, 1'b0, 32'h0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b0;
      set_in(1'b0, 1'b0, 1'b0, 32'h0);
      mem[0] = 32'h00221820;
      mem[1] = 32'h8C4B0001;
      mem[2] = 32'hAC430001;
      for (int i = 3; i < 25; i++) mem[i] = $urandom;
      test_reset();
      test_sequential();
      test_stall();
      test_redirect_over_stall();
      test_fault_recovery();
      test_range_end();
      test_reset_in_fault();
      test_illegal_reset_pc();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
